// File: rtl/base_pkg.sv
// ---------------------------------------------------------------------------
// base_pkg
// Shared APB types and constants for the APB bridge family.
//   apb_req_t        : APB request  (paddr, psel, penable, pwrite, pwdata, pstrb)
//   apb_resp_t       : APB response (prdata, pready, pslverr)
//   apb_mux_state_e  : transfer FSM state of apb_to_simple_if_multi
//   MAX_CH           : upper bound on the number of memory channels
// ---------------------------------------------------------------------------
package base_pkg;

    localparam int unsigned MAX_CH = 8;
    localparam int unsigned APB_AW = 32;
    localparam int unsigned APB_DW = 32;

    typedef struct packed {
        logic [APB_AW-1:0]   paddr;
        logic                psel;
        logic                penable;
        logic                pwrite;
        logic [APB_DW-1:0]   pwdata;
        logic [APB_DW/8-1:0] pstrb;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DW-1:0] prdata;
        logic              pready;
        logic              pslverr;
    } apb_resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } apb_mux_state_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// ---------------------------------------------------------------------------
// apb_addr_decoder
// Combinational match of an address against NUM_CH channel windows.
//   paddr      in  [63:0]           address (zero-extended APB paddr)
//   hit        out [NUM_CH-1:0]     one-hot match, lowest channel index wins
//   local_addr out [MEM_SIZE-1:0]   address relative to the winning base
// Window i covers [CH_BASE[i], CH_BASE[i] + 2^MEM_SIZE).
// ---------------------------------------------------------------------------
module apb_addr_decoder
    import base_pkg::*;
#(
    parameter int unsigned NUM_CH             = 2,
    parameter int unsigned MEM_SIZE           = 12,
    parameter logic [63:0] CH_BASE [NUM_CH]   = '{64'h0, 64'h1000}
) (
    input  logic [63:0]          paddr,
    output logic [NUM_CH-1:0]    hit,
    output logic [MEM_SIZE-1:0]  local_addr
);

    logic        found;
    logic [64:0] lo;
    logic [64:0] hi;

    always_comb begin
        hit        = '0;
        local_addr = '0;
        found      = 1'b0;
        lo         = '0;
        hi         = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            // 65-bit bounds so a window ending at 2^64 does not wrap
            lo = {1'b0, CH_BASE[i]};
            hi = lo + (65'd1 << MEM_SIZE);
            if (!found && ({1'b0, paddr} >= lo) && ({1'b0, paddr} < hi)) begin
                found      = 1'b1;
                hit[i]     = 1'b1;
                local_addr = MEM_SIZE'(paddr - CH_BASE[i]);
            end
        end
    end

endmodule

// File: rtl/apb_to_simple_if_multi.sv
// ---------------------------------------------------------------------------
// apb_to_simple_if_multi
// APB slave decoding one APB port onto NUM_CH simple-memory channels.
//   clk_i, arst_i   clock (rising edge), asynchronous active-high reset
//   req_i, resp_o   APB request / response structs
//   mem_we_o/mem_re_o        per-channel one-cycle write/read strobes
//   mem_waddr_o/mem_raddr_o  per-channel local address (MEM_SIZE bits)
//   mem_wdata_o/mem_wstrb_o  write data and byte strobes, shared
//   mem_wvalid_i/mem_wresp_i write completion and response (nonzero = error)
//   mem_rdata_i/mem_rvalid_i/mem_rresp_i  read data, valid and response
// Optional feature macro: APB_TO_SIMPLE_IF_MULTI_TIMEOUT_EN
//   defined  : an access with no valid for TIMEOUT_CYCLES cycles ends in error
//   undefined: the bridge waits for the valid indefinitely
// ---------------------------------------------------------------------------
module apb_to_simple_if_multi
    import base_pkg::*;
#(
    parameter type         req_t              = base_pkg::apb_req_t,
    parameter type         resp_t             = base_pkg::apb_resp_t,
    parameter int unsigned NUM_CH             = 2,
    parameter logic [63:0] CH_BASE [NUM_CH]   = '{64'h0, 64'h1000},
    parameter int unsigned MEM_SIZE           = 12,
    parameter int unsigned TIMEOUT_CYCLES     = 16,
    parameter int unsigned DW                 = base_pkg::APB_DW
) (
    input  logic                              clk_i,
    input  logic                              arst_i,
    input  req_t                              req_i,
    output resp_t                             resp_o,
    output logic [NUM_CH-1:0]                 mem_we_o,
    output logic [NUM_CH-1:0][MEM_SIZE-1:0]   mem_waddr_o,
    output logic [DW-1:0]                     mem_wdata_o,
    output logic [DW/8-1:0]                   mem_wstrb_o,
    input  logic [NUM_CH-1:0]                 mem_wvalid_i,
    input  logic [NUM_CH-1:0][1:0]            mem_wresp_i,
    output logic [NUM_CH-1:0]                 mem_re_o,
    output logic [NUM_CH-1:0][MEM_SIZE-1:0]   mem_raddr_o,
    input  logic [NUM_CH-1:0][DW-1:0]         mem_rdata_i,
    input  logic [NUM_CH-1:0]                 mem_rvalid_i,
    input  logic [NUM_CH-1:0][1:0]            mem_rresp_i
);

    if (NUM_CH < 1 || NUM_CH > MAX_CH || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256)
    begin : g_bad_cfg
        $error("apb_to_simple_if_multi: NUM_CH or TIMEOUT_CYCLES out of range");
    end

    apb_mux_state_e            state;
    logic [NUM_CH-1:0]         hit;
    logic [NUM_CH-1:0]         hit_q;
    logic [MEM_SIZE-1:0]       local_addr;
    logic                      write_q;
    logic                      aborted_q;
    logic [DW-1:0]             prdata_q;
    logic                      pready_q;
    logic                      pslverr_q;
    logic                      sel_valid;
    logic                      sel_err;
    logic [DW-1:0]             sel_rdata;

`ifdef APB_TO_SIMPLE_IF_MULTI_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q;
`endif

    apb_addr_decoder #(
        .NUM_CH   (NUM_CH),
        .MEM_SIZE (MEM_SIZE),
        .CH_BASE  (CH_BASE)
    ) u_dec (
        .paddr      (64'(req_i.paddr)),
        .hit        (hit),
        .local_addr (local_addr)
    );

    // Response of the channel latched at setup; hit_q is one-hot.
    always_comb begin
        sel_valid = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (hit_q[i]) begin
                sel_valid = write_q ? mem_wvalid_i[i]  : mem_rvalid_i[i];
                sel_err   = write_q ? |mem_wresp_i[i]  : |mem_rresp_i[i];
                sel_rdata = write_q ? '0               : mem_rdata_i[i];
            end
        end
    end

    always_comb begin
        resp_o         = '0;
        resp_o.prdata  = prdata_q;
        resp_o.pready  = pready_q;
        resp_o.pslverr = pslverr_q;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state       <= IDLE;
            hit_q       <= '0;
            write_q     <= 1'b0;
            aborted_q   <= 1'b0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            mem_we_o    <= '0;
            mem_re_o    <= '0;
            mem_waddr_o <= '0;
            mem_raddr_o <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
`ifdef APB_TO_SIMPLE_IF_MULTI_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            mem_we_o <= '0;
            mem_re_o <= '0;
            case (state)
                IDLE: begin
                    aborted_q <= 1'b0;
                    if (req_i.psel && !req_i.penable) begin
                        if (|hit) begin
                            state       <= ISSUE;
                            hit_q       <= hit;
                            write_q     <= req_i.pwrite;
                            mem_wdata_o <= req_i.pwdata;
                            mem_wstrb_o <= req_i.pstrb;
                            mem_we_o    <= req_i.pwrite ? hit : '0;
                            mem_re_o    <= req_i.pwrite ? '0  : hit;
                            for (int unsigned i = 0; i < NUM_CH; i++) begin
                                mem_waddr_o[i] <= hit[i] ? local_addr : '0;
                                mem_raddr_o[i] <= hit[i] ? local_addr : '0;
                            end
`ifdef APB_TO_SIMPLE_IF_MULTI_TIMEOUT_EN
                            cnt_q <= '0;
`endif
                        end else begin
                            state     <= DONE;
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                            prdata_q  <= '0;
                        end
                    end
                end

                ISSUE, WAIT: begin
                    state <= WAIT;
                    if (!req_i.psel) aborted_q <= 1'b1;
`ifdef APB_TO_SIMPLE_IF_MULTI_TIMEOUT_EN
                    cnt_q <= cnt_q + 8'd1;
`endif
                    // An abandoned transfer still completes on the memory side
                    // but returns silently to IDLE.
                    if (sel_valid) begin
                        if (aborted_q || !req_i.psel) begin
                            state <= IDLE;
                        end else begin
                            state     <= DONE;
                            pready_q  <= 1'b1;
                            pslverr_q <= sel_err;
                            prdata_q  <= sel_rdata;
                        end
                    end
`ifdef APB_TO_SIMPLE_IF_MULTI_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        if (aborted_q || !req_i.psel) begin
                            state <= IDLE;
                        end else begin
                            state     <= DONE;
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                            prdata_q  <= '0;
                        end
                    end
`endif
                end

                DONE: begin
                    state     <= IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_to_simple_if_multi.sv
// ---------------------------------------------------------------------------
// tb_apb_to_simple_if_multi
// Directed bench for apb_to_simple_if_multi with two channels at 0x0 and
// 0x1000, 4 KiB windows. Cycle names: T0 = APB setup cycle, T1 = first
// access cycle, and so on.
// ---------------------------------------------------------------------------
module tb_apb_to_simple_if_multi;
    import base_pkg::*;

    logic                 clk = 1'b0;
    logic                 arst;
    apb_req_t             req;
    apb_resp_t            resp;
    logic [1:0]           mem_we;
    logic [1:0]           mem_re;
    logic [1:0][11:0]     waddr;
    logic [1:0][11:0]     raddr;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic [1:0]           wvalid;
    logic [1:0][1:0]      wresp;
    logic [1:0][31:0]     rdata;
    logic [1:0]           rvalid;
    logic [1:0][1:0]      rresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_to_simple_if_multi #(
        .NUM_CH         (2),
        .CH_BASE        ('{64'h0, 64'h1000}),
        .MEM_SIZE       (12),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .req_i        (req),
        .resp_o       (resp),
        .mem_we_o     (mem_we),
        .mem_waddr_o  (waddr),
        .mem_wdata_o  (wdata),
        .mem_wstrb_o  (wstrb),
        .mem_wvalid_i (wvalid),
        .mem_wresp_i  (wresp),
        .mem_re_o     (mem_re),
        .mem_raddr_o  (raddr),
        .mem_rdata_i  (rdata),
        .mem_rvalid_i (rvalid),
        .mem_rresp_i  (rresp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives the setup phase (T0), then the access phase (T1) one cycle later.
    task automatic apb_start(input logic [31:0] a, input logic w,
                             input logic [31:0] d, input logic [3:0] s);
        step();
        req.paddr   = a;
        req.psel    = 1'b1;
        req.penable = 1'b0;
        req.pwrite  = w;
        req.pwdata  = d;
        req.pstrb   = s;
        step();
        req.penable = 1'b1;
    endtask

    task automatic bus_idle();
        req.psel    = 1'b0;
        req.penable = 1'b0;
        wvalid      = '0;
        rvalid      = '0;
        wresp       = '0;
        rresp       = '0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        @(negedge clk);
        checks++;
        if (resp !== '0) begin
            errors++; $display("FAIL reset_resp got %h exp 0", resp);
        end
        checks++;
        if ({mem_we, mem_re} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes got %b exp 0", {mem_we, mem_re});
        end
        checks++;
        if ({waddr, raddr, wdata, wstrb} !== '0) begin
            errors++; $display("FAIL reset_addr_data got %h exp 0", {waddr, raddr, wdata, wstrb});
        end
        step();
        arst = 1'b0;
    endtask

    task automatic test_write_ch1();
        apb_start(32'h1004, 1'b1, 32'hDEADBEEF, 4'hF);
        wvalid = 2'b10;
        @(negedge clk);
        checks++;
        if (mem_we !== 2'b10 || mem_re !== 2'b00) begin
            errors++; $display("FAIL wr_strobe got we=%b re=%b exp we=10 re=00", mem_we, mem_re);
        end
        checks++;
        if (waddr[1] !== 12'h004) begin
            errors++; $display("FAIL wr_addr got %h exp 004", waddr[1]);
        end
        checks++;
        if (wdata !== 32'hDEADBEEF || wstrb !== 4'hF) begin
            errors++; $display("FAIL wr_data got %h/%h exp deadbeef/f", wdata, wstrb);
        end
        checks++;
        if (resp.pready !== 1'b0) begin
            errors++; $display("FAIL wr_early_ready got %b exp 0", resp.pready);
        end
        step();
        wvalid = 2'b00;
        @(negedge clk);
        checks++;
        if (resp.pready !== 1'b1 || resp.pslverr !== 1'b0 || resp.prdata !== 32'h0) begin
            errors++; $display("FAIL wr_done got rdy=%b err=%b rd=%h exp 1 0 0",
                               resp.pready, resp.pslverr, resp.prdata);
        end
        checks++;
        if (mem_we !== 2'b00) begin
            errors++; $display("FAIL wr_strobe_len got %b exp 00", mem_we);
        end
        step();
        bus_idle();
        @(negedge clk);
        checks++;
        if (resp.pready !== 1'b0) begin
            errors++; $display("FAIL wr_ready_drop got %b exp 0", resp.pready);
        end
    endtask

    task automatic test_read_latency();
        apb_start(32'h0000_0010, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        checks++;
        if (mem_re !== 2'b01 || raddr[0] !== 12'h010) begin
            errors++; $display("FAIL rd_strobe got re=%b addr=%h exp 01/010", mem_re, raddr[0]);
        end
        // T2: a valid from the non-selected channel must be ignored
        step();
        rvalid   = 2'b10;
        rresp[1] = 2'b11;
        rdata[1] = 32'h0BAD;
        @(negedge clk);
        checks++;
        if (mem_re !== 2'b00 || resp.pready !== 1'b0) begin
            errors++; $display("FAIL rd_wait got re=%b rdy=%b exp 00/0", mem_re, resp.pready);
        end
        step();
        rvalid = 2'b00;
        rresp  = '0;
        @(negedge clk);
        checks++;
        if (resp.pready !== 1'b0) begin
            errors++; $display("FAIL rd_other_ch got rdy=%b exp 0", resp.pready);
        end
        step();
        rvalid   = 2'b01;
        rdata[0] = 32'h1234;
        @(negedge clk);
        checks++;
        if (resp.pready !== 1'b0) begin
            errors++; $display("FAIL rd_same_cycle got rdy=%b exp 0", resp.pready);
        end
        step();
        rvalid = 2'b00;
        @(negedge clk);
        checks++;
        if (resp.pready !== 1'b1 || resp.pslverr !== 1'b0 || resp.prdata !== 32'h1234) begin
            errors++; $display("FAIL rd_done got rdy=%b err=%b rd=%h exp 1 0 1234",
                               resp.pready, resp.pslverr, resp.prdata);
        end
        step();
        bus_idle();
    endtask

    task automatic test_miss();
        apb_start(32'h5000, 1'b1, 32'h55AA, 4'hF);
        @(negedge clk);
        checks++;
        if (resp.pready !== 1'b1 || resp.pslverr !== 1'b1 || resp.prdata !== 32'h0) begin
            errors++; $display("FAIL miss_resp got rdy=%b err=%b rd=%h exp 1 1 0",
                               resp.pready, resp.pslverr, resp.prdata);
        end
        checks++;
        if (mem_we !== 2'b00 || mem_re !== 2'b00) begin
            errors++; $display("FAIL miss_strobe got we=%b re=%b exp 00/00", mem_we, mem_re);
        end
        step();
        bus_idle();
        @(negedge clk);
        checks++;
        if (resp.pready !== 1'b0 || mem_we !== 2'b00) begin
            errors++; $display("FAIL miss_after got rdy=%b we=%b exp 0/00", resp.pready, mem_we);
        end
    endtask

    task automatic test_error_resp();
        apb_start(32'h1010, 1'b0, 32'h0, 4'h0);
        rvalid   = 2'b10;
        rresp[1] = 2'b10;
        rdata[1] = 32'hAAAA;
        step();
        rvalid = 2'b00;
        rresp  = '0;
        @(negedge clk);
        checks++;
        if (resp.pready !== 1'b1 || resp.pslverr !== 1'b1 || resp.prdata !== 32'hAAAA) begin
            errors++; $display("FAIL err_resp got rdy=%b err=%b rd=%h exp 1 1 aaaa",
                               resp.pready, resp.pslverr, resp.prdata);
        end
        step();
        bus_idle();
    endtask

    task automatic test_pstrb_zero();
        apb_start(32'h0FFC, 1'b1, 32'h0F0F_0F0F, 4'h0);
        wvalid = 2'b01;
        @(negedge clk);
        checks++;
        if (mem_we !== 2'b01 || waddr[0] !== 12'hFFC || wstrb !== 4'h0) begin
            errors++; $display("FAIL strb0_issue got we=%b addr=%h strb=%h exp 01/ffc/0",
                               mem_we, waddr[0], wstrb);
        end
        step();
        wvalid = 2'b00;
        @(negedge clk);
        checks++;
        if (resp.pready !== 1'b1 || resp.pslverr !== 1'b0) begin
            errors++; $display("FAIL strb0_done got rdy=%b err=%b exp 1 0", resp.pready, resp.pslverr);
        end
        step();
        bus_idle();
    endtask

    task automatic test_reset_in_wait();
        apb_start(32'h0020, 1'b0, 32'h0, 4'h0);
        step();
        arst = 1'b1;
        @(negedge clk);
        checks++;
        if (resp !== '0 || {mem_we, mem_re} !== 4'b0 ||
            {waddr, raddr, wdata, wstrb} !== '0) begin
            errors++; $display("FAIL rst_wait_outputs got resp=%h st=%b ad=%h exp 0",
                               resp, {mem_we, mem_re}, {waddr, raddr, wdata, wstrb});
        end
        step();
        arst = 1'b0;
        bus_idle();
        step();
        @(negedge clk);
        checks++;
        if (resp.pready !== 1'b0 || mem_re !== 2'b00) begin
            errors++; $display("FAIL rst_wait_idle got rdy=%b re=%b exp 0/00", resp.pready, mem_re);
        end
        apb_start(32'h1100, 1'b1, 32'hCAFE_F00D, 4'h3);
        wvalid = 2'b10;
        @(negedge clk);
        checks++;
        if (mem_we !== 2'b10 || waddr[1] !== 12'h100) begin
            errors++; $display("FAIL rst_wr_issue got we=%b addr=%h exp 10/100", mem_we, waddr[1]);
        end
        step();
        wvalid = 2'b00;
        @(negedge clk);
        checks++;
        if (resp.pready !== 1'b1 || resp.pslverr !== 1'b0) begin
            errors++; $display("FAIL rst_wr_done got rdy=%b err=%b exp 1 0", resp.pready, resp.pslverr);
        end
        step();
        bus_idle();
    endtask

`ifdef APB_TO_SIMPLE_IF_MULTI_TIMEOUT_EN
    task automatic test_timeout();
        apb_start(32'h1008, 1'b0, 32'h0, 4'h0);
        for (int i = 2; i <= 16; i++) step();
        @(negedge clk);
        checks++;
        if (resp.pready !== 1'b0) begin
            errors++; $display("FAIL to_early got rdy=%b exp 0", resp.pready);
        end
        step();
        @(negedge clk);
        checks++;
        if (resp.pready !== 1'b1 || resp.pslverr !== 1'b1 || resp.prdata !== 32'h0) begin
            errors++; $display("FAIL to_done got rdy=%b err=%b rd=%h exp 1 1 0",
                               resp.pready, resp.pslverr, resp.prdata);
        end
        step();
        bus_idle();
        rvalid   = 2'b10;
        rdata[1] = 32'hFFFF;
        step();
        rvalid = 2'b00;
        @(negedge clk);
        checks++;
        if (resp.pready !== 1'b0 || mem_re !== 2'b00) begin
            errors++; $display("FAIL to_late_valid got rdy=%b re=%b exp 0/00", resp.pready, mem_re);
        end
        apb_start(32'h1008, 1'b0, 32'h0, 4'h0);
        rvalid   = 2'b10;
        rdata[1] = 32'h7777;
        step();
        rvalid = 2'b00;
        @(negedge clk);
        checks++;
        if (resp.pready !== 1'b1 || resp.pslverr !== 1'b0 || resp.prdata !== 32'h7777) begin
            errors++; $display("FAIL to_next got rdy=%b err=%b rd=%h exp 1 0 7777",
                               resp.pready, resp.pslverr, resp.prdata);
        end
        step();
        bus_idle();
    endtask
`endif

    initial begin
        req   = '0;
        rdata = '0;
        bus_idle();
        test_reset();
        test_write_ch1();
        test_read_latency();
        test_miss();
        test_error_resp();
        test_pstrb_zero();
        test_reset_in_wait();
`ifdef APB_TO_SIMPLE_IF_MULTI_TIMEOUT_EN
        test_timeout();
`endif
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_to_simple_if_multi.md
# apb_to_simple_if_multi

APB slave bridge that decodes one APB port onto `NUM_CH` independent simple-memory channels, each with its own base address and window. It succeeds the single-channel APB-to-simple-if bridge and adds:
- multi-channel address decode;
- a valid-qualified memory response, so memories may take multiple cycles;
- a decode-miss error;
- an optional response timeout.

It sits between the APB interconnect and on-chip memories/register files.

## Interface
- `req_t`, `base_pkg::apb_req_t`, APB request struct (`paddr`, `psel`, `penable`, `pwrite`, `pwdata`, `pstrb`)
- `resp_t`, `base_pkg::apb_resp_t`, APB response struct (`prdata`, `pready`, `pslverr`)
- `NUM_CH`, 2, number of memory channels (1..8)
- `CH_BASE`, `'{64'h0, 64'h1000}`, per-channel base address array of `logic [63:0]`; each base is aligned to its window
- `MEM_SIZE`, 12, channel window = 2^`MEM_SIZE` bytes; also the width of each local address
- `TIMEOUT_CYCLES`, 16, wait limit; only used with the timeout feature
- `clk_i`  in  1  clock; everything is on the rising edge
- `arst_i`  in  1  reset; asynchronous, active-high
- `req_i`  in  `req_t`  APB request
- `resp_o`  out  `resp_t`  APB response
- `mem_we_o`  out  `[NUM_CH-1:0]`  per-channel write strobe, one cycle
- `mem_waddr_o`  out  `[NUM_CH-1:0][MEM_SIZE-1:0]`  local write address
- `mem_wdata_o`  out  `[DW-1:0]`  write data, shared by all channels
- `mem_wstrb_o`  out  `[DW/8-1:0]`  byte strobes, shared by all channels
- `mem_wvalid_i`  in  `[NUM_CH-1:0]`  write completion
- `mem_wresp_i`  in  `[NUM_CH-1:0][1:0]`  write response; nonzero = error
- `mem_re_o`  out  `[NUM_CH-1:0]`  per-channel read strobe, one cycle
- `mem_raddr_o`  out  `[NUM_CH-1:0][MEM_SIZE-1:0]`  local read address
- `mem_rdata_i`  in  `[NUM_CH-1:0][DW-1:0]`  read data
- `mem_rvalid_i`  in  `[NUM_CH-1:0]`  read data valid
- `mem_rresp_i`  in  `[NUM_CH-1:0][1:0]`  read response; nonzero = error

`DW` = `$bits(req_i.pwdata)`.

## Operation
**FSM states:** `IDLE`, `ISSUE`, `WAIT`, `DONE`.

**`IDLE`**
- On `psel & !penable` (setup phase), register the following, then decode:
  - `paddr`, `pwrite`, `pwdata`, `pstrb`;
  - one-hot hit vector: `hit[i] = (paddr >= CH_BASE[i]) && (paddr < CH_BASE[i] + 2^MEM_SIZE)`.
- If more than one channel hits, the lowest index wins.
- Hit: go to `ISSUE`.
- Miss: go to `DONE` with error = 1 and `prdata` = 0. No memory strobe is issued.

**`ISSUE`**
- Drive `mem_we_o[ch]` or `mem_re_o[ch]` high for exactly one cycle.
- Local address = `(paddr - CH_BASE[ch])[MEM_SIZE-1:0]`, driven on both address buses of that channel.
- Sample the selected channel's valid in this cycle. If set, go to `DONE`; otherwise go to `WAIT`.

**`WAIT`**
- Strobes are low.
- On the selected channel's `wvalid` (write) or `rvalid` (read):
  - latch `rdata` (reads only);
  - error = `|resp`;
  - go to `DONE`.

**`DONE`**
- `pready` = 1 for one cycle, with the latched `prdata` and `pslverr`; then go to `IDLE`.
- Write transfers return `prdata` = 0.

**Boundary conditions**
- Valids from non-selected channels, and any valid seen in `IDLE` or `DONE`, are ignored.
- `pstrb` = 0 on a write is forwarded unchanged; it is not an error.
- If `psel` drops before `DONE` (protocol violation), the memory access still completes. The FSM then returns to `IDLE` without asserting `pready`.
- Reset asserted mid-transfer: the FSM goes to `IDLE` immediately and all outputs return to their reset values. No memory strobe is emitted after reset.

## Timing
- **Reset values:** `pready`, `pslverr`, `prdata`, all strobes, addresses, `wdata` and `wstrb` are all 0.
- Setup cycle = T0.
- Strobe in T1.
- Earliest `pready` is T2, when the valid arrives in T1.
- General case: `pready` comes 1 cycle after the valid.
- Decode miss: `pready` = 1 with `pslverr` = 1 in T1, the first access cycle.
- Address, `wdata` and `wstrb` are registered and held stable from `ISSUE` until the FSM returns to `IDLE`.
- Only one transfer is outstanding at a time; there is no pipelining.

## Configuration
Macro: `APB_TO_SIMPLE_IF_MULTI_TIMEOUT_EN`.
- **Defined:** an 8-bit cycle counter clears on entry to `ISSUE` and counts in `ISSUE`/`WAIT`.
  - If `TIMEOUT_CYCLES` cycles elapse with no valid, go to `DONE` with `pslverr` = 1 and `prdata` = 0.
  - A valid that arrives afterwards is ignored.
- **Undefined:** no counter; `WAIT` holds indefinitely.

## Structure
- `base_pkg` holds:
  - the state enum `apb_mux_state_e`;
  - a `MAX_CH` = 8 constant;
  - the `apb_req_t`/`apb_resp_t` typedefs, which already exist there.
- One sub-module, `apb_addr_decoder`: a combinational match of `paddr` against `CH_BASE`/`MEM_SIZE`, producing the one-hot `hit` vector and the local address.

## Test plan
- **Write to channel 1:** `paddr` = 0x1004, `pwdata` = 0xDEADBEEF, `pstrb` = 0xF, `wvalid` returned the same cycle.
  - Expect `mem_we_o` = 2'b10 in T1 and `mem_waddr_o[1]` = 0x004.
  - Expect `pready` in T2 with `pslverr` = 0.
- **Read from channel 0 with 3-cycle latency:** `paddr` = 0x10, `rvalid` 3 cycles after the strobe, `rdata` = 0x1234.
  - Expect `prdata` = 0x1234 one cycle after `rvalid`.
- **Unmapped address:** `paddr` = 0x5000.
  - Expect `pready` and `pslverr` = 1 in T1 and no strobe on either channel.
- **Error response:** read with `rresp` = 2'b10.
  - Expect `pslverr` = 1.
- **Timeout (`APB_TO_SIMPLE_IF_MULTI_TIMEOUT_EN` defined, `TIMEOUT_CYCLES` = 16):** no valid returned.
  - Expect `pslverr` = 1 after 16 cycles.
  - A late `rvalid` is ignored, and the next transfer completes normally.
- **Reset in `WAIT`:** assert `arst_i` while the FSM is in `WAIT`.
  - Expect all outputs at 0 and the FSM in `IDLE`.
  - A following write completes with `pready` at T2.
